// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered valid/ready ALU with iterative unsigned DIV/MOD
// Optional ALU_SEQ_MUL_EN: MUL uses the iterative shift-add path instead of a combinational multiplier.
module alu_seq #(
  parameter int N   = 19,
  parameter int SHW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [2:0]   flags,
  output logic         div0
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MOD   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_PASSA = 3'b111;

  localparam int             CW  = $clog2(N);
  localparam logic [SHW-1:0] SHN = SHW'(N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          w_out_adv;
  logic          w_accept;
  logic          w_iter_op;
  logic          w_start;

  logic          r_p_valid;
  logic [N-1:0]  r_p_a;
  logic [N-1:0]  r_p_b;
  logic [2:0]    r_p_op;

  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_dvs;
  logic [2:0]    r_it_op;
  logic [CW-1:0] r_cnt;

  logic [N:0]    w_rem_sh;
  logic          w_ge;
  logic [N-1:0]  w_rem_nxt;
  logic [N-1:0]  w_quo_nxt;

  logic [N-1:0]  w_h_res;
  logic          w_h_o;

  logic [SHW-1:0] w_shamt;
  logic [N-1:0]  w_add;
  logic [N-1:0]  w_sub;
  logic [N-1:0]  w_s_res;
  logic          w_s_o;
  logic          w_s_div0;

  logic [N-1:0]  w_ld_res;
  logic          w_ld_o;
  logic          w_ld_div0;

`ifdef ALU_SEQ_MUL_EN
  logic [N:0]    w_sum;
`else
  logic [2*N-1:0] w_prod;
`endif

  assign w_out_adv = !out_valid || out_ready;
  assign in_ready  = (r_state == IDLE) && w_out_adv;
  assign w_accept  = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  assign w_iter_op = ((op == OP_DIV || op == OP_MOD) && (b != '0)) || (op == OP_MUL);
`else
  assign w_iter_op = (op == OP_DIV || op == OP_MOD) && (b != '0);
`endif
  assign w_start = w_accept && w_iter_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HOLD waits for the output register to free up before loading the iterative result
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = DIVIDE;
      DIVIDE:  if (r_cnt == CW'(N - 1)) w_state_nxt = HOLD;
      HOLD:    if (w_out_adv) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p_valid <= 1'b0;
      r_p_a     <= '0;
      r_p_b     <= '0;
      r_p_op    <= OP_ADD;
    end else begin
      if (w_out_adv) r_p_valid <= w_accept && !w_iter_op;
      if (w_accept) begin
        r_p_a  <= a;
        r_p_b  <= b;
        r_p_op <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_it_op <= OP_DIV;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_rem   <= '0;
      r_quo   <= a;
      r_dvs   <= b;
      r_it_op <= op;
      r_cnt   <= '0;
    end else if (r_state == DIVIDE) begin
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Restoring division: dividend bits leave r_quo MSB-first while quotient bits enter at the LSB
  always_comb begin
    w_rem_sh  = {r_rem, r_quo[N-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_dvs});
    w_rem_nxt = w_ge ? N'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[N-1:0];
    w_quo_nxt = {r_quo[N-2:0], w_ge};
`ifdef ALU_SEQ_MUL_EN
    w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_dvs} : '0);
    if (r_it_op == OP_MUL) begin
      w_rem_nxt = w_sum[N:1];
      w_quo_nxt = {w_sum[0], r_quo[N-1:1]};
    end
`endif
  end

  always_comb begin
    w_h_res = (r_it_op == OP_MOD) ? r_rem : r_quo;
    w_h_o   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    if (r_it_op == OP_MUL) w_h_o = |r_rem;
`endif
  end

`ifdef ALU_SEQ_MUL_EN
`else
  assign w_prod = {{N{1'b0}}, r_p_a} * {{N{1'b0}}, r_p_b};
`endif

  // DIV/MOD only reach this stage when the divisor is zero
  always_comb begin
    w_s_res  = '0;
    w_s_o    = 1'b0;
    w_s_div0 = 1'b0;
    w_shamt  = r_p_b[SHW-1:0];
    w_add    = r_p_a + r_p_b;
    w_sub    = r_p_a - r_p_b;
    case (r_p_op)
      OP_ADD: begin
        w_s_res = w_add;
        w_s_o   = (r_p_a[N-1] == r_p_b[N-1]) && (w_add[N-1] != r_p_a[N-1]);
      end
      OP_SUB: begin
        w_s_res = w_sub;
        w_s_o   = (r_p_a[N-1] != r_p_b[N-1]) && (w_sub[N-1] != r_p_a[N-1]);
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        w_s_res = '0;
`else
        w_s_res = w_prod[N-1:0];
        w_s_o   = |w_prod[2*N-1:N];
`endif
      end
      OP_DIV: begin
        w_s_res  = '1;
        w_s_div0 = 1'b1;
      end
      OP_MOD: begin
        w_s_res  = r_p_a;
        w_s_div0 = 1'b1;
      end
      OP_SHL:   w_s_res = (w_shamt >= SHN) ? '0 : (r_p_a << w_shamt);
      OP_PASSB: w_s_res = r_p_b;
      OP_PASSA: w_s_res = r_p_a;
      default:  w_s_res = '0;
    endcase
  end

  assign w_ld_res  = r_p_valid ? w_s_res : w_h_res;
  assign w_ld_o    = r_p_valid ? w_s_o : w_h_o;
  assign w_ld_div0 = r_p_valid && w_s_div0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      div0      <= 1'b0;
    end else if (w_out_adv) begin
      if (r_p_valid || (r_state == HOLD)) begin
        out_valid <= 1'b1;
        result    <= w_ld_res;
        flags     <= {(w_ld_res == '0), w_ld_o, w_ld_res[N-1]};
        div0      <= w_ld_div0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
